// File: rtl/cp_manager_pkg.sv
// Shared types and constants for the rename-stage branch checkpoint scheduler.
package cp_manager_pkg;

    localparam int unsigned RAT_CP_SIZE       = 8;
    localparam int unsigned RAT_CP_INDEX_SIZE = 3;

    typedef logic [RAT_CP_INDEX_SIZE-1:0] cp_index_t;

    typedef enum logic {
        CP_IDLE    = 1'b0,
        CP_RESTORE = 1'b1
    } cp_state_t;

    // Total set bits of a vector of up to 32 bits.
    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cp_manager_popcount_prefix.sv
// Exclusive per-slot prefix popcount plus total, used to rank branches within a group.
module cp_manager_popcount_prefix #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            bits_i,
    output logic [WIDTH-1:0][CNT_W-1:0] prefix_o,
    output logic [CNT_W-1:0]            total_o
);

    always_comb begin
        logic [CNT_W-1:0] acc;
        acc      = '0;
        prefix_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            prefix_o[i] = acc;
            acc         = acc + CNT_W'(bits_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/cp_manager.sv
// Branch checkpoint scheduler: allocates slots per rename group, frees on retire,
// truncates the live window on mispredict and sequences the one-cycle RAT restore.
module cp_manager
    import cp_manager_pkg::*;
#(
    parameter int unsigned RENAME_WIDTH  = 4,
    parameter int unsigned COMMIT_WIDTH  = 4,
    parameter int unsigned CP_SIZE       = RAT_CP_SIZE,
    parameter int unsigned CP_INDEX_SIZE = RAT_CP_INDEX_SIZE
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  alloc_req,
    input  logic [RENAME_WIDTH-1:0]               alloc_valid,
    input  logic [RENAME_WIDTH-1:0]               alloc_is_br,
    output logic                                  alloc_ready,
    output logic [RENAME_WIDTH*CP_INDEX_SIZE-1:0] alloc_idx,
    output logic [RENAME_WIDTH-1:0]               alloc_take,
    input  logic [COMMIT_WIDTH-1:0]               retire_valid,
    input  logic [COMMIT_WIDTH-1:0]               retire_is_br,
    input  logic                                  recover,
    input  logic [CP_INDEX_SIZE-1:0]              recover_idx,
    input  logic                                  flush_all,
    output logic                                  restore_req,
    output logic [CP_INDEX_SIZE-1:0]              restore_idx,
    output logic [CP_INDEX_SIZE-1:0]              cp_head,
    output logic [CP_INDEX_SIZE:0]                cp_count,
    output logic                                  cp_full,
    output logic                                  cp_empty,
    output logic                                  err
);

    localparam int unsigned CNT_W = CP_INDEX_SIZE + 1;
    localparam int unsigned RPC_W = $clog2(RENAME_WIDTH + 1);
    localparam int unsigned CPC_W = $clog2(COMMIT_WIDTH + 1);

    cp_state_t                         state_q, state_d;
    logic [CP_INDEX_SIZE-1:0]          head_q, head_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              restore_req_q, restore_req_d;
    logic [CP_INDEX_SIZE-1:0]          restore_idx_q, restore_idx_d;
    logic                              err_q, err_d;

    logic [RENAME_WIDTH-1:0]            br_bits;
    logic [RENAME_WIDTH-1:0][RPC_W-1:0] br_prefix;
    logic [RPC_W-1:0]                   nbr;
    logic [CPC_W-1:0]                   nret;
    logic [CNT_W-1:0]                   free_cnt;
    logic [CNT_W-1:0]                   cnt_ret;
    logic [CP_INDEX_SIZE-1:0]           head_ret;
    logic [CP_INDEX_SIZE-1:0]           tail;
    logic [CP_INDEX_SIZE-1:0]           rec_off;
    logic                               ret_err;
    logic                               fire;

    assign br_bits = alloc_valid & alloc_is_br;

    cp_manager_popcount_prefix #(.WIDTH(RENAME_WIDTH)) u_alloc_pc (
        .bits_i   (br_bits),
        .prefix_o (br_prefix),
        .total_o  (nbr)
    );

    assign nret     = CPC_W'(popcount32(32'(retire_valid & retire_is_br)));
    // Same-cycle retires are deliberately not credited to free space.
    assign free_cnt = CNT_W'(CP_SIZE) - count_q;
    assign tail     = CP_INDEX_SIZE'(head_q + count_q[CP_INDEX_SIZE-1:0]);

    assign alloc_ready = (state_q == CP_IDLE) & ~recover & ~flush_all & (CNT_W'(nbr) <= free_cnt);
    assign fire        = alloc_req & alloc_ready;
    assign alloc_take  = fire ? br_bits : '0;

    always_comb begin
        alloc_idx = '0;
        for (int i = 0; i < int'(RENAME_WIDTH); i++) begin
            if (br_bits[i]) begin
                alloc_idx[i*CP_INDEX_SIZE +: CP_INDEX_SIZE] =
                    CP_INDEX_SIZE'(tail + CP_INDEX_SIZE'(br_prefix[i]));
            end
        end
    end

    // Retire first, then flush/recover, then allocation.
    always_comb begin
        head_ret = CP_INDEX_SIZE'(head_q + CP_INDEX_SIZE'(nret));
        ret_err  = 1'b0;
        cnt_ret  = count_q - CNT_W'(nret);
        if (CNT_W'(nret) > count_q) begin
            ret_err = 1'b1;
            cnt_ret = '0;
        end
        rec_off = CP_INDEX_SIZE'(recover_idx - head_ret);

        state_d       = CP_IDLE;
        head_d        = head_ret;
        count_d       = cnt_ret;
        restore_req_d = 1'b0;
        restore_idx_d = restore_idx_q;
        err_d         = err_q | ret_err;

        if (flush_all) begin
            count_d = '0;
        end else if (state_q == CP_RESTORE) begin
            if (recover) begin
                err_d = 1'b1;
            end
        end else if (recover) begin
            if (CNT_W'(rec_off) < cnt_ret) begin
                count_d = CNT_W'(rec_off) + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
            restore_idx_d = recover_idx;
            restore_req_d = 1'b1;
            state_d       = CP_RESTORE;
        end else if (fire) begin
            count_d = cnt_ret + CNT_W'(nbr);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CP_IDLE;
            head_q        <= '0;
            count_q       <= '0;
            restore_req_q <= 1'b0;
            restore_idx_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            count_q       <= count_d;
            restore_req_q <= restore_req_d;
            restore_idx_q <= restore_idx_d;
            err_q         <= err_d;
        end
    end

    assign restore_req = restore_req_q;
    assign restore_idx = restore_idx_q;
    assign cp_head     = head_q;
    assign cp_count    = count_q;
    assign cp_full     = (count_q == CNT_W'(CP_SIZE));
    assign cp_empty    = (count_q == '0);
    assign err         = err_q;

endmodule

// File: tb/tb_cp_manager.sv
// Scoreboard bench for cp_manager: stimulus queues expected grants, restores and
// status values; a negedge monitor pops and compares them against the DUT.
module tb_cp_manager;
    import cp_manager_pkg::*;

    localparam int SEL_READY   = 0;
    localparam int SEL_COUNT   = 1;
    localparam int SEL_HEAD    = 2;
    localparam int SEL_ERR     = 3;
    localparam int SEL_FULL    = 4;
    localparam int SEL_EMPTY   = 5;
    localparam int SEL_RESTORE = 6;

    typedef struct { int cyc; logic [3:0] take; logic [11:0] idx; } grant_t;
    typedef struct { int cyc; cp_index_t idx; } rest_t;
    typedef struct { string name; int sel; logic [7:0] val; } stat_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_req;
    logic [3:0]  alloc_valid, alloc_is_br, alloc_take;
    logic        alloc_ready;
    logic [11:0] alloc_idx;
    logic [3:0]  retire_valid, retire_is_br;
    logic        recover, flush_all, restore_req;
    cp_index_t   recover_idx, restore_idx, cp_head;
    logic [3:0]  cp_count;
    logic        cp_full, cp_empty, err;

    grant_t grant_q[$];
    rest_t  rest_q[$];
    stat_t  stat_q[$];
    grant_t g_m;
    rest_t  r_m;
    stat_t  s_m;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clock = ~clock;

    cp_manager dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_is_br  (alloc_is_br),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .alloc_take   (alloc_take),
        .retire_valid (retire_valid),
        .retire_is_br (retire_is_br),
        .recover      (recover),
        .recover_idx  (recover_idx),
        .flush_all    (flush_all),
        .restore_req  (restore_req),
        .restore_idx  (restore_idx),
        .cp_head      (cp_head),
        .cp_count     (cp_count),
        .cp_full      (cp_full),
        .cp_empty     (cp_empty),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d): got unexpected/missing event expected none", name, cyc);
    endtask

    function automatic logic [31:0] read_sel(input int sel);
        case (sel)
            SEL_READY:   return 32'(alloc_ready);
            SEL_COUNT:   return 32'(cp_count);
            SEL_HEAD:    return 32'(cp_head);
            SEL_ERR:     return 32'(err);
            SEL_FULL:    return 32'(cp_full);
            SEL_EMPTY:   return 32'(cp_empty);
            SEL_RESTORE: return 32'(restore_req);
            default:     return 32'hdead_beef;
        endcase
    endfunction

    function automatic logic [11:0] idx4(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clock) begin
        if (!reset) begin
            while (stat_q.size() > 0) begin
                s_m = stat_q.pop_front();
                check(s_m.name, read_sel(s_m.sel), 32'(s_m.val));
            end
            if (alloc_take != 4'b0) begin
                if (grant_q.size() == 0) fail_event("grant_unexpected");
                else begin
                    g_m = grant_q.pop_front();
                    check("grant_cycle", 32'(cyc), 32'(g_m.cyc));
                    check("grant_take", 32'(alloc_take), 32'(g_m.take));
                    check("grant_idx", 32'(alloc_idx), 32'(g_m.idx));
                end
            end
            while (grant_q.size() > 0 && grant_q[0].cyc <= cyc) begin
                g_m = grant_q.pop_front();
                fail_event("grant_missing");
            end
            if (restore_req) begin
                if (rest_q.size() == 0) fail_event("restore_unexpected");
                else begin
                    r_m = rest_q.pop_front();
                    check("restore_cycle", 32'(cyc), 32'(r_m.cyc));
                    check("restore_idx", 32'(restore_idx), 32'(r_m.idx));
                end
            end
            while (rest_q.size() > 0 && rest_q[0].cyc <= cyc) begin
                r_m = rest_q.pop_front();
                fail_event("restore_missing");
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        alloc_req    = 1'b0;
        alloc_valid  = '0;
        alloc_is_br  = '0;
        retire_valid = '0;
        retire_is_br = '0;
        recover      = 1'b0;
        recover_idx  = '0;
        flush_all    = 1'b0;
    endtask

    task automatic exp_stat(input string n, input int sel, input int v);
        stat_q.push_back('{n, sel, 8'(v)});
    endtask

    task automatic exp_grant(input logic [3:0] t, input logic [11:0] idx);
        grant_q.push_back('{cyc, t, idx});
    endtask

    task automatic exp_restore(input int idx);
        rest_q.push_back('{cyc, 3'(idx)});
    endtask

    task automatic do_alloc(input logic [3:0] v, input logic [3:0] b);
        alloc_req   = 1'b1;
        alloc_valid = v;
        alloc_is_br = b;
    endtask

    task automatic do_retire(input logic [3:0] v, input logic [3:0] b);
        retire_valid = v;
        retire_is_br = b;
    endtask

    initial begin
        reset = 1'b1;
        alloc_req = 1'b0; alloc_valid = '0; alloc_is_br = '0;
        retire_valid = '0; retire_is_br = '0;
        recover = 1'b0; recover_idx = '0; flush_all = 1'b0;
        repeat (2) @(posedge clock);

        step(); reset = 1'b0;                                  // head 0, count 0
        exp_stat("rst_count", SEL_COUNT, 0);
        exp_stat("rst_head", SEL_HEAD, 0);
        exp_stat("rst_err", SEL_ERR, 0);
        exp_stat("rst_empty", SEL_EMPTY, 1);
        exp_stat("rst_restore", SEL_RESTORE, 0);
        do_alloc(4'b1111, 4'b1010);
        exp_stat("first_ready", SEL_READY, 1);
        exp_grant(4'b1010, idx4(0, 0, 0, 1));

        step();                                                // count 2
        exp_stat("first_count", SEL_COUNT, 2);
        do_alloc(4'b1111, 4'b1111);
        exp_grant(4'b1111, idx4(2, 3, 4, 5));

        step();                                                // count 6
        exp_stat("fill_count6", SEL_COUNT, 6);
        do_alloc(4'b0001, 4'b0001);
        exp_grant(4'b0001, idx4(6, 0, 0, 0));

        step();                                                // count 7, 2 branches won't fit
        do_alloc(4'b1111, 4'b0011);
        exp_stat("nofit_ready", SEL_READY, 0);
        exp_stat("nofit_count", SEL_COUNT, 7);
        exp_stat("nofit_full", SEL_FULL, 0);

        step();                                                // retire not credited this cycle
        do_alloc(4'b1111, 4'b0011);
        do_retire(4'b0001, 4'b0001);
        exp_stat("retire_nocredit_ready", SEL_READY, 0);
        exp_stat("retire_nocredit_count", SEL_COUNT, 7);

        step();                                                // head 1, count 6, tail 7
        do_alloc(4'b1111, 4'b0011);
        exp_stat("after_retire_ready", SEL_READY, 1);
        exp_stat("after_retire_head", SEL_HEAD, 1);
        exp_stat("after_retire_count", SEL_COUNT, 6);
        exp_grant(4'b0011, idx4(7, 0, 0, 0));

        step();                                                // full
        exp_stat("full_count", SEL_COUNT, 8);
        exp_stat("full_flag", SEL_FULL, 1);
        exp_stat("full_ready_nobr", SEL_READY, 1);

        step();
        do_retire(4'b1111, 4'b1111);                           // -> head 5, count 4

        step();                                                // flush blocks alloc
        do_retire(4'b0001, 4'b0001);
        flush_all = 1'b1;
        do_alloc(4'b0001, 4'b0001);
        exp_stat("flush_ready", SEL_READY, 0);
        exp_stat("pre_flush_count", SEL_COUNT, 4);
        exp_stat("pre_flush_head", SEL_HEAD, 5);

        step();                                                // head 6, count 0: wrap
        exp_stat("wrap_head", SEL_HEAD, 6);
        exp_stat("wrap_empty", SEL_EMPTY, 1);
        do_alloc(4'b1111, 4'b1111);
        exp_grant(4'b1111, idx4(6, 7, 0, 1));

        step();                                                // retire 4 + alloc 4
        exp_stat("wrap_count", SEL_COUNT, 4);
        exp_stat("wrap_head2", SEL_HEAD, 6);
        do_retire(4'b1111, 4'b1111);
        do_alloc(4'b1111, 4'b1111);
        exp_grant(4'b1111, idx4(2, 3, 4, 5));

        step();
        exp_stat("mix_head", SEL_HEAD, 2);
        exp_stat("mix_count", SEL_COUNT, 4);
        do_alloc(4'b0001, 4'b0001);
        exp_grant(4'b0001, idx4(6, 0, 0, 0));

        step();                                                // head 2, count 5: recover 4
        exp_stat("prerec_count", SEL_COUNT, 5);
        recover = 1'b1; recover_idx = 3'd4;
        do_retire(4'b0001, 4'b0001);
        exp_stat("rec_ready", SEL_READY, 0);

        step();                                                // RESTORE cycle
        exp_stat("rec_head", SEL_HEAD, 3);
        exp_stat("rec_count", SEL_COUNT, 2);
        exp_stat("restore_ready", SEL_READY, 0);
        exp_restore(4);

        step();
        exp_stat("post_restore_ready", SEL_READY, 1);
        exp_stat("post_restore_req", SEL_RESTORE, 0);

        step();                                                // flush beats recover
        recover = 1'b1; recover_idx = 3'd3;
        flush_all = 1'b1;

        step();
        exp_stat("flushrec_count", SEL_COUNT, 0);
        exp_stat("flushrec_restore", SEL_RESTORE, 0);
        exp_stat("flushrec_ready", SEL_READY, 1);
        exp_stat("flushrec_head", SEL_HEAD, 3);
        do_alloc(4'b0001, 4'b0001);
        exp_grant(4'b0001, idx4(3, 0, 0, 0));

        step();                                                // over-retire
        exp_stat("pre_over_count", SEL_COUNT, 1);
        exp_stat("pre_over_err", SEL_ERR, 0);
        do_retire(4'b0011, 4'b0011);

        step();
        exp_stat("over_err", SEL_ERR, 1);
        exp_stat("over_count", SEL_COUNT, 0);
        exp_stat("over_head", SEL_HEAD, 5);
        do_alloc(4'b0111, 4'b0111);
        exp_grant(4'b0111, idx4(5, 6, 7, 0));

        step();                                                // window 5..7, recover 1 is outside
        exp_stat("sticky_err", SEL_ERR, 1);
        exp_stat("pre_bad_count", SEL_COUNT, 3);
        recover = 1'b1; recover_idx = 3'd1;

        step();
        exp_stat("bad_rec_count", SEL_COUNT, 3);
        exp_stat("bad_rec_err", SEL_ERR, 1);
        exp_stat("bad_rec_ready", SEL_READY, 0);
        exp_restore(1);

        step();
        exp_stat("end_ready", SEL_READY, 1);
        exp_stat("end_count", SEL_COUNT, 3);
        exp_stat("end_head", SEL_HEAD, 5);

        step();
        step();
        if (grant_q.size() != 0) fail_event("grant_leftover");
        if (rest_q.size() != 0) fail_event("restore_leftover");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
